// File: rtl/stream_dup_map_n_pkg.sv
// Shared types and constants for the stream_dup_map_n fan-out block.
// Mode encodings, FSM state type and an index-width helper.
package stream_dup_map_n_pkg;

    localparam int MODE_DUP   = 0;
    localparam int MODE_SPLIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Keeps index registers at least one bit wide even when N is 1.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_dup_map_n_fifo.sv
// Per-channel FIFO with a registered count and no fall-through.
// Head data reads as zero whenever the FIFO is empty.
module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pushOk;
    logic          popOk;

    assign pushOk  = push_i && (count_q != CW'(DEPTH));
    assign popOk   = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;

    always_comb begin
        count_d = count_q;
        if (pushOk && !popOk) begin
            count_d = count_q + 1'b1;
        end else if (popOk && !pushOk) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
            if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/stream_dup_map_n.sv
// N-channel stream fan-out: broadcast (DUP) or round-robin (SPLIT),
// adding a per-channel offset before each channel's FIFO.
module stream_dup_map_n
    import stream_dup_map_n_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int MODE  = MODE_DUP
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic [N*W-1:0] offset,
    input  logic [W-1:0]   sIn,
    input  logic           sIn_valid,
    output logic           sIn_ready,
    output logic [N*W-1:0] sOut,
    output logic [N-1:0]   sOut_valid,
    input  logic [N-1:0]   sOut_ready
);
    localparam int RW = idxWidth(N);

    state_e         state_q;
    logic [N*W-1:0] off_q;
    logic [RW-1:0]  rr_q;
    logic [N-1:0]   full;
    logic [N-1:0]   push;
    logic           accept;
    logic           unusedOutReady;

    assign unusedOutReady = out_ready;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);

    // Depends only on registered state and counts, never on sOut_ready.
    always_comb begin
        sIn_ready = 1'b0;
        if (state_q == ST_RUN) begin
            if (MODE == MODE_DUP) begin
                sIn_ready = ~|full;
            end else begin
                sIn_ready = !full[rr_q];
            end
        end
    end

    assign accept = sIn_valid && sIn_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        off_q   <= offset;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (MODE == MODE_SPLIT && accept) begin
                        rr_q <= (rr_q == RW'(N - 1)) ? '0 : rr_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : gChan
        logic [W-1:0] mapped;

        assign mapped  = sIn + off_q[k*W +: W];
        assign push[k] = accept && ((MODE == MODE_DUP) || (rr_q == RW'(k)));

        stream_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) uFifo (
            .clk     (clk),
            .nrst    (nrst),
            .push_i  (push[k]),
            .data_i  (mapped),
            .pop_i   (sOut_ready[k]),
            .data_o  (sOut[k*W +: W]),
            .valid_o (sOut_valid[k]),
            .full_o  (full[k])
        );
    end

endmodule
